// File: rtl/lif_pkg.sv
// Shared types and defaults for the time-multiplexed LIF neuron scheduler.
// Holds the FSM state encoding and the saturating membrane-update helper.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int          DEF_N_NEURONS  = 4;
    localparam int          DEF_V_W        = 8;
    localparam int unsigned DEF_THRESHOLD  = 200;
    localparam int          DEF_LEAK_SHIFT = 1;
    localparam int          DEF_W_CHAIN    = 255;
    localparam int          DEF_REFRAC     = 2;

    // v - (v >> shift) + i, evaluated one bit wider than the operands and clamped to vmax.
    function automatic logic [31:0] sat_add(
        input logic [31:0] v,
        input logic [31:0] i,
        input int          shift,
        input logic [31:0] vmax
    );
        logic [32:0] sum;
        sum = {1'b0, v - (v >> shift)} + {1'b0, i};
        return (sum > {1'b0, vmax}) ? vmax : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Purpose: combinational single-neuron LIF update (leak, integrate, fire, refractory).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the scheduler decides when results are written back.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int          V_W        = DEF_V_W,
    parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
    parameter int          LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int          REFRAC     = DEF_REFRAC,
    parameter int          REF_W      = 2
) (
    input  logic [V_W-1:0]   v,
    input  logic [REF_W-1:0] ref_cnt,
    input  logic [V_W-1:0]   isyn,
    output logic [V_W-1:0]   v_next,
    output logic [REF_W-1:0] ref_next,
    output logic             spike
);

    localparam logic [31:0] V_MAX = 32'((64'd1 << V_W) - 64'd1);

    logic [31:0] v_upd;

    always_comb begin
        v_upd    = sat_add(32'(v), 32'(isyn), LEAK_SHIFT, V_MAX);
        v_next   = v_upd[V_W-1:0];
        ref_next = ref_cnt;
        spike    = 1'b0;
        if (ref_cnt != '0) begin
            // Refractory neurons are clamped at rest and ignore their input.
            ref_next = ref_cnt - REF_W'(1);
            v_next   = '0;
        end else if (v_upd >= THRESHOLD) begin
            spike    = 1'b1;
            v_next   = '0;
            ref_next = REF_W'(REFRAC);
        end
    end

endmodule

// File: rtl/lif_step_scheduler.sv
// Purpose: sequences N_NEURONS chained LIF neurons through one shared update core, one neuron per cycle.
// Latency: step_i in cycle t -> done_o in t+N_NEURONS+1; next step accepted from t+N_NEURONS+2.
// Backpressure: step_i is dropped while busy_o; LIF_SCHED_OVERRUN_EN adds a sticky overrun_o flag for that.
module lif_step_scheduler
    import lif_pkg::*;
#(
    parameter int          N_NEURONS  = DEF_N_NEURONS,
    parameter int          V_W        = DEF_V_W,
    parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
    parameter int          LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int          W_CHAIN    = DEF_W_CHAIN,
    parameter int          REFRAC     = DEF_REFRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_i,
    input  logic [V_W-1:0]       ext_isyn_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_NEURONS-1:0] spike_o
`ifdef LIF_SCHED_OVERRUN_EN
    ,
    output logic                 overrun_o,
    input  logic                 clr_overrun_i
`endif
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]     idx_q;
    logic [V_W-1:0]       ext_q;
    logic [V_W-1:0]       v_q   [N_NEURONS];
    logic [REF_W-1:0]     ref_q [N_NEURONS];
    logic [N_NEURONS-1:0] scratch_q;
    logic [N_NEURONS-1:0] scratch_upd;
    logic [N_NEURONS-1:0] spike_q;

    logic [V_W-1:0]   core_isyn;
    logic [V_W-1:0]   core_v_next;
    logic [REF_W-1:0] core_ref_next;
    logic             core_spike;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_i) state_d = UPDATE;
            UPDATE:  if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign spike_o = spike_q;

    // Neuron 0 takes the external drive; every later neuron is driven by its predecessor's spike this step.
    always_comb begin
        core_isyn = '0;
        if (idx_q == '0)                        core_isyn = ext_q;
        else if (scratch_q[idx_q - IDX_W'(1)])  core_isyn = V_W'(W_CHAIN);
    end

    always_comb begin
        scratch_upd        = scratch_q;
        scratch_upd[idx_q] = core_spike;
    end

    lif_update_core #(
        .V_W        (V_W),
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .REF_W      (REF_W)
    ) u_core (
        .v        (v_q[idx_q]),
        .ref_cnt  (ref_q[idx_q]),
        .isyn     (core_isyn),
        .v_next   (core_v_next),
        .ref_next (core_ref_next),
        .spike    (core_spike)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            ext_q     <= '0;
            scratch_q <= '0;
            spike_q   <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_q[k]   <= '0;
                ref_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_i) begin
                        ext_q     <= ext_isyn_i;
                        idx_q     <= '0;
                        scratch_q <= '0;
                    end
                end
                UPDATE: begin
                    v_q[idx_q]   <= core_v_next;
                    ref_q[idx_q] <= core_ref_next;
                    scratch_q    <= scratch_upd;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        // Loaded on the way into DONE so spike_o is already valid while done_o is high.
                        spike_q <= scratch_upd;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LIF_SCHED_OVERRUN_EN
    // A dropped step outranks a simultaneous clear so no overrun is ever lost.
    always_ff @(posedge clk) begin
        if (rst)                   overrun_o <= 1'b0;
        else if (step_i && busy_o) overrun_o <= 1'b1;
        else if (clr_overrun_i)    overrun_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler with default parameters (N=4, V_W=8, THRESHOLD=200, REFRAC=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lif_step_scheduler;

    logic       clk;
    logic       rst;
    logic       step_i;
    logic [7:0] ext_isyn_i;
    logic       busy_o;
    logic       done_o;
    logic [3:0] spike_o;
`ifdef LIF_SCHED_OVERRUN_EN
    logic       overrun_o;
    logic       clr_overrun_i;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    lif_step_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .step_i        (step_i),
        .ext_isyn_i    (ext_isyn_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .spike_o       (spike_o)
`ifdef LIF_SCHED_OVERRUN_EN
        ,
        .overrun_o     (overrun_o),
        .clr_overrun_i (clr_overrun_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        step_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one step and waits (bounded) for done_o; lat = cycles after acceptance, -1 on timeout.
    task automatic run_step(input logic [7:0] ext, output int lat, output logic [3:0] spk);
        @(negedge clk);
        step_i     = 1'b1;
        ext_isyn_i = ext;
        @(negedge clk);
        step_i = 1'b0;
        lat    = -1;
        spk    = 4'h0;
        for (int c = 1; c <= 20; c++) begin
            if (lat < 0 && done_o) begin
                lat = c;
                spk = spike_o;
            end
            if (lat < 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [3:0] spk;
        apply_reset();
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy busy_o=%b exp=0", busy_o); end
        n_tests++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done done_o=%b exp=0", done_o); end
        n_tests++;
        if (spike_o !== 4'b0000) begin n_fail++; $display("FAIL reset_spike spike_o=%b exp=0000", spike_o); end
`ifdef LIF_SCHED_OVERRUN_EN
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun overrun_o=%b exp=0", overrun_o); end
`endif
        run_step(8'd0, lat, spk);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL reset_step_lat lat=%0d exp=5", lat); end
        n_tests++;
        if (spk !== 4'b0000) begin n_fail++; $display("FAIL reset_step_spike spike_o=%b exp=0000", spk); end
    endtask

    task automatic test_latency();
        logic exp_busy;
        logic exp_done;
        apply_reset();
        @(negedge clk);
        step_i     = 1'b1;
        ext_isyn_i = 8'd0;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL lat_busy_t0 busy_o=%b exp=0", busy_o); end
        @(negedge clk);
        step_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_busy = (c <= 5);
            exp_done = (c == 5);
            n_tests++;
            if (busy_o !== exp_busy) begin n_fail++; $display("FAIL lat_busy c=%0d busy_o=%b exp=%b", c, busy_o, exp_busy); end
            n_tests++;
            if (done_o !== exp_done) begin n_fail++; $display("FAIL lat_done c=%0d done_o=%b exp=%b", c, done_o, exp_done); end
            @(negedge clk);
        end
    endtask

    task automatic test_refractory();
        int lat;
        logic [3:0] spk;
        logic [3:0] exp_spk [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            run_step(8'd255, lat, spk);
            n_tests++;
            if (spk !== exp_spk[s]) begin n_fail++; $display("FAIL refrac step%0d spike_o=%b exp=%b", s + 1, spk, exp_spk[s]); end
        end
    endtask

    // ext=50 settles at V0 = 50,75,88,94,97 (below threshold); ext=100 climbs 100,150,175,188,194,197,199,200.
    task automatic test_leak();
        int lat;
        logic [3:0] spk;
        apply_reset();
        for (int s = 1; s <= 5; s++) begin
            run_step(8'd50, lat, spk);
            n_tests++;
            if (spk !== 4'b0000) begin n_fail++; $display("FAIL leak50 step%0d spike_o=%b exp=0000", s, spk); end
        end
        apply_reset();
        for (int s = 1; s <= 8; s++) begin
            run_step(8'd100, lat, spk);
            n_tests++;
            if (spk !== ((s == 8) ? 4'b1111 : 4'b0000)) begin
                n_fail++;
                $display("FAIL leak100 step%0d spike_o=%b exp=%b", s, spk, (s == 8) ? 4'b1111 : 4'b0000);
            end
        end
    endtask

    // V0=199 after seven ext=100 steps; 199-99+255=355 must clamp to 255 (fires), not wrap to 99.
    task automatic test_saturation();
        int lat;
        logic [3:0] spk;
        apply_reset();
        for (int s = 1; s <= 7; s++) run_step(8'd100, lat, spk);
        n_tests++;
        if (spk !== 4'b0000) begin n_fail++; $display("FAIL sat_pre spike_o=%b exp=0000", spk); end
        run_step(8'd255, lat, spk);
        n_tests++;
        if (spk !== 4'b1111) begin n_fail++; $display("FAIL sat_fire spike_o=%b exp=1111", spk); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (spike_o !== 4'b1111) begin n_fail++; $display("FAIL spike_hold spike_o=%b exp=1111", spike_o); end
    endtask

    task automatic test_busy_step();
        int dones;
        logic [3:0] spk;
        apply_reset();
        dones = 0;
        spk   = 4'h0;
        @(negedge clk);
        step_i     = 1'b1;
        ext_isyn_i = 8'd255;
        @(negedge clk);
        step_i     = 1'b0;
        ext_isyn_i = 8'd0;
        for (int c = 1; c <= 12; c++) begin
            if (done_o) begin dones++; spk = spike_o; end
            if (c == 2) step_i = 1'b1;
            if (c == 3) step_i = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (dones !== 1) begin n_fail++; $display("FAIL busy_step_dones count=%0d exp=1", dones); end
        n_tests++;
        if (spk !== 4'b1111) begin n_fail++; $display("FAIL busy_step_spike spike_o=%b exp=1111", spk); end
`ifdef LIF_SCHED_OVERRUN_EN
        n_tests++;
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_set overrun_o=%b exp=1", overrun_o); end
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clr overrun_o=%b exp=0", overrun_o); end
`endif
    endtask

    task automatic test_step_held();
        apply_reset();
        @(negedge clk);
        step_i     = 1'b1;
        ext_isyn_i = 8'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_tests++;
            if (done_o !== ((c % 6) == 5)) begin
                n_fail++;
                $display("FAIL held_done c=%0d done_o=%b exp=%b", c, done_o, (c % 6) == 5);
            end
            if (c == 12) step_i = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL held_release busy_o=%b exp=0", busy_o); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [3:0] spk;
        apply_reset();
        run_step(8'd255, lat, spk);
        n_tests++;
        if (spk !== 4'b1111) begin n_fail++; $display("FAIL rstmid_pre spike_o=%b exp=1111", spk); end
        @(negedge clk);
        step_i     = 1'b1;
        ext_isyn_i = 8'd255;
        @(negedge clk);
        step_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Now in the idx=2 update cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy busy_o=%b exp=0", busy_o); end
        n_tests++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done done_o=%b exp=0", done_o); end
        n_tests++;
        if (spike_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_spike spike_o=%b exp=0000", spike_o); end
        run_step(8'd0, lat, spk);
        n_tests++;
        if (spk !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ext0 spike_o=%b exp=0000", spk); end
        // Refractory counters were cleared, so full drive fires the whole chain again.
        run_step(8'd255, lat, spk);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL rstmid_lat lat=%0d exp=5", lat); end
        n_tests++;
        if (spk !== 4'b1111) begin n_fail++; $display("FAIL rstmid_fire spike_o=%b exp=1111", spk); end
    endtask

    initial begin
        rst        = 1'b1;
        step_i     = 1'b0;
        ext_isyn_i = 8'd0;
`ifdef LIF_SCHED_OVERRUN_EN
        clr_overrun_i = 1'b0;
`endif
        test_reset();
        test_latency();
        test_refractory();
        test_leak();
        test_saturation();
        test_busy_step();
        test_step_held();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
